// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy/status flags
// and an optional overwrite-oldest mode that counts discarded words.
module sync_fifo #(
  parameter int DEPTH         = 64,
  parameter int WIDTH         = 512,
  parameter int OVERWRITE     = 0,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic [31:0]              drop_cnt
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [WIDTH-1:0]    mem [DEPTH];

  logic [ADDR_WIDTH:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                aFull_q, aFull_d;
  logic                aEmpty_q, aEmpty_d;
  logic                overflow_q, overflow_d;
  logic [31:0]         dropCnt_q, dropCnt_d;

  logic                wrEn;
  logic                rdEn;
  logic                dropEn;

  assign s_ready = !rst && ((OVERWRITE != 0) || !full_q);
  assign m_valid = !empty_q;
  assign m_data  = mem[rdPtr_q[ADDR_WIDTH-1:0]];

  // A write into a full FIFO in overwrite mode pushes the head out, so the
  // read pointer advances even though no consumer took the word.
  always_comb begin
    wrEn       = s_valid && s_ready;
    rdEn       = m_valid && m_ready;
    dropEn     = (OVERWRITE != 0) && full_q && wrEn && !rdEn;

    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    dropCnt_d  = dropCnt_q;
    overflow_d = dropEn;

    if (wrEn) wrPtr_d = wrPtr_q + PTR_ONE;
    if (rdEn || dropEn) rdPtr_d = rdPtr_q + PTR_ONE;

    case ({wrEn, rdEn})
      2'b10:   if (!dropEn) count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase

    if (dropEn && (dropCnt_q != 32'hFFFF_FFFF)) dropCnt_d = dropCnt_q + 32'd1;

    full_d   = (wrPtr_d[ADDR_WIDTH] != rdPtr_d[ADDR_WIDTH]) &&
               (wrPtr_d[ADDR_WIDTH-1:0] == rdPtr_d[ADDR_WIDTH-1:0]);
    empty_d  = (wrPtr_d == rdPtr_d);
    aFull_d  = (count_d >= AFULL_LVL);
    aEmpty_d = (count_d <= AEMPTY_LVL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      aFull_q    <= 1'b0;
      aEmpty_q   <= 1'b1;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      aFull_q    <= aFull_d;
      aEmpty_q   <= aEmpty_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Storage is deliberately left unreset; wrEn is already gated by reset.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr_q[ADDR_WIDTH-1:0]] <= s_data;
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = aFull_q;
  assign almost_empty = aEmpty_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = dropCnt_q;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of storage words; power of two, minimum 4.
REQ-002 SHALL have parameter WIDTH, default 512: data word width in bits.
REQ-003 SHALL have parameter OVERWRITE, default 0: 0 = backpressure when full; 1 = a write when full overwrites the oldest word.
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-4: almost_full threshold in words.
REQ-005 SHALL have parameter AEMPTY_THRESH, default 4: almost_empty threshold in words.
REQ-006 SHALL define local ADDR_WIDTH = $clog2(DEPTH).
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port s_data, input, WIDTH bits: write data.
REQ-010 SHALL have port s_valid, input, 1 bit: write request.
REQ-011 SHALL have port s_ready, output, 1 bit: write accepted this cycle when high with s_valid.
REQ-012 SHALL have port m_data, output, WIDTH bits: head-of-queue data.
REQ-013 SHALL have port m_valid, output, 1 bit: m_data holds a valid word.
REQ-014 SHALL have port m_ready, input, 1 bit: read request.
REQ-015 SHALL have port count, output, ADDR_WIDTH+1 bits: occupancy, 0..DEPTH.
REQ-016 SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: status flags.
REQ-017 SHALL have port overflow, output, 1 bit: one-cycle pulse when the oldest word is discarded.
REQ-018 SHALL have port drop_cnt, output, 32 bits: saturating count of discarded words.

Function
REQ-019 SHALL keep wr_ptr and rd_ptr at ADDR_WIDTH+1 bits, so all DEPTH entries are usable; full = (ptr MSBs differ and low bits equal), empty = (ptrs equal).
REQ-020 SHALL operate first-word-fall-through: m_data = mem[rd_ptr[ADDR_WIDTH-1:0]] and m_valid = !empty.
REQ-021 SHALL define a write as s_valid && s_ready and a read as m_valid && m_ready, each taking effect at the clock edge.
REQ-022 SHALL drive s_ready = !rst && !full when OVERWRITE=0, and s_ready = !rst when OVERWRITE=1.
REQ-023 SHALL give write-to-read latency of one cycle: a word written into an empty FIFO at edge N gives m_valid=1 and the word on m_data in the cycle after edge N.
REQ-024 SHALL, on a write with no read, store s_data at wr_ptr, increment wr_ptr and increment count.
REQ-025 SHALL, on a read with no write, increment rd_ptr and decrement count.
REQ-026 SHALL, on a simultaneous read and write, advance both pointers and leave count unchanged, including when full.
REQ-027 SHALL, when empty and s_valid is high, treat the cycle as a write only; no read occurs because m_valid=0.
REQ-028 SHALL, when OVERWRITE=1, full and a write occurs with no read, store the word, advance both wr_ptr and rd_ptr, hold count at DEPTH, pulse overflow for exactly one cycle and increment drop_cnt.
REQ-029 SHALL hold drop_cnt at 0xFFFFFFFF once reached, and never let it increment when OVERWRITE=0.
REQ-030 SHALL wrap pointers modulo 2*DEPTH without any special case.
REQ-031 SHALL register count, full, empty, almost_full and almost_empty, and update them at the same edge as the pointers, so they are always mutually consistent.
REQ-032 SHALL compute almost_full = (count >= AFULL_THRESH) and almost_empty = (count <= AEMPTY_THRESH), evaluated on the next-state count.
REQ-033 SHALL leave memory contents unreset; only control state is reset.

Reset
REQ-034 SHALL, while rst is high at an edge, set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0 and drop_cnt=0, ignoring s_valid and m_ready.
REQ-035 SHALL, when rst is asserted mid-operation, discard all stored words, with m_valid=0 in the cycle after the reset edge.
REQ-036 SHALL hold s_ready=0 during rst, and assert it in the first cycle after rst deasserts.

Verification
REQ-037 Fill test, DEPTH=64, OVERWRITE=0: 64 writes with m_ready=0 -> count=64, full=1, s_ready=0; a 65th s_valid is refused; 64 reads return data in order 0..63, then empty=1.
REQ-038 Overwrite test, OVERWRITE=1: write 0..63, then write 64 -> overflow pulses one cycle, drop_cnt=1, count=64, first read returns 1.
REQ-039 Simultaneous test: when full, read+write for 10 cycles -> count stays 64, no overflow; when empty, s_valid with m_ready=1 -> count=1 next cycle.
REQ-040 Threshold test: with AFULL_THRESH=60 and AEMPTY_THRESH=4, almost_full rises on the edge where count becomes 60, and almost_empty falls when count becomes 5.
REQ-041 Reset test: with count=37, assert rst for 1 cycle -> count=0, empty=1, m_valid=0 and drop_cnt=0 next cycle; a subsequent write reads back correctly.
REQ-042 Wrap test: 1000 random read/write cycles checked against a reference queue model -> data order, count and flags match every cycle.
